// File: rtl/instr_encoder.sv
// RV32I field-level instruction encoder feeding an instruction-memory write port.
// Requests {op, rd, rs1, rs2, imm} are packed into R/I/U/S/B words and written
// one per cycle from a programmable base address, up to DEPTH words per session.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready and
// start is low. in_ready depends only on registered state, never on in_valid.
// A transferred request either produces exactly one mem_we cycle on the next
// cycle, or is rejected (sets err, no write, no address/count change).
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = ADDR_W + 2;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_U = 7'b0110111;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  state_t            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [ADDR_W-1:0] wr_ptr_q;   // address the next accepted word will use

  logic [CW-1:0]     fill;
  logic [ADDR_W:0]   count_inc;
  logic              accept;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              imm_fits12;
  logic              imm_fits_b;

  // Words committed or in flight; the pending write counts against DEPTH.
  assign fill      = CW'(count_q) + CW'(mem_we_q);
  assign count_inc = count_q + {{ADDR_W{1'b0}}, mem_we_q};
  assign in_ready  = (state_q == S_LOAD) && (fill < CW'(DEPTH));
  assign accept    = in_valid && in_ready && !start;

  // Signed immediate range checks: 12-bit for ADDI/SW, even 13-bit for branches.
  assign imm_fits12 = (imm[31:11] == {21{imm[11]}});
  assign imm_fits_b = (imm[31:12] == {20{imm[12]}}) && !imm[0];

  // Pack the request into an RV32I word and flag whether it is encodable.
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b0;
    case (op)
      4'd0:  begin enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R}; enc_ok = 1'b1; end // ADD
      4'd1:  begin enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R}; enc_ok = 1'b1; end // SUB
      4'd2:  begin enc_word = {7'b0000000, rs2, rs1, 3'b100, rd, OPC_R}; enc_ok = 1'b1; end // XOR
      4'd3:  begin enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R}; enc_ok = 1'b1; end // OR
      4'd4:  begin enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R}; enc_ok = 1'b1; end // AND
      4'd5:  begin enc_word = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R}; enc_ok = 1'b1; end // SLL
      4'd6:  begin enc_word = {7'b0000000, rs2, rs1, 3'b101, rd, OPC_R}; enc_ok = 1'b1; end // SRL
      4'd7:  begin enc_word = {7'b0100000, rs2, rs1, 3'b101, rd, OPC_R}; enc_ok = 1'b1; end // SRA
      4'd8:  begin enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R}; enc_ok = 1'b1; end // SLT
      4'd9:  begin enc_word = {7'b0000000, rs2, rs1, 3'b011, rd, OPC_R}; enc_ok = 1'b1; end // SLTU
      4'd10: begin // ADDI
        enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_I};
        enc_ok   = imm_fits12;
      end
      4'd11: begin // LUI: low 12 bits must be zero, the upper 20 are taken as-is
        enc_word = {imm[31:12], rd, OPC_U};
        enc_ok   = (imm[11:0] == 12'h000);
      end
      4'd12: begin // SW
        enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_S};
        enc_ok   = imm_fits12;
      end
      4'd13: begin // BNE
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_B};
        enc_ok   = imm_fits_b;
      end
      4'd14: begin // BEQ
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B};
        enc_ok   = imm_fits_b;
      end
      default: begin
        enc_word = 32'h0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // Session FSM with registered write port; start overrides any pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
    end else if (start) begin
      state_q  <= S_LOAD;
      mem_we_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= base_addr;
    end else begin
      mem_we_q <= 1'b0;
      count_q  <= count_inc;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (enc_ok) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q;
              mem_wdata_q <= enc_word;
              wr_ptr_q    <= wr_ptr_q + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          // The last write has retired when count reaches DEPTH; nothing can be pending.
          if (count_inc == (ADDR_W+1)'(DEPTH)) begin
            state_q <= S_DONE;
          end
        end
        S_IDLE:  state_q <= S_IDLE;
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign count       = count_q;
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=8, DEPTH=4 so session-full is reachable).
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        op = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state_o;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .done(done), .err(err),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];   // {addr, data} expected writes
  logic [39:0] obs_q[$];   // {addr, data} observed writes
  int tests = 0;
  int fails = 0;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic sb_check(input string tag);
    logic [39:0] o, e;
    chk({tag, "_nwr"}, 40'(obs_q.size()), 40'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_wr"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    int guard;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("send_timeout", 40'(in_ready), 40'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [31:0] t5_data [5];
  int acc;
  int k;

  // ---------------- directed sequence ----------------
  initial begin
    t5_data[0] = 32'h00100093; // ADDI x1,x0,1
    t5_data[1] = 32'h00200113; // ADDI x2,x0,2
    t5_data[2] = 32'h00300193; // ADDI x3,x0,3
    t5_data[3] = 32'h00400213; // ADDI x4,x0,4
    t5_data[4] = 32'h00500293; // ADDI x5,x0,5 (never accepted)

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 40'(in_ready), 40'd0);
    chk("rst_outputs", {mem_we, mem_addr, count, done, err}, 40'd0);
    chk("rst_wdata", 40'(mem_wdata), 40'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 40'(in_ready), 40'd0);

    // T1: ADDI, one-cycle latency
    do_start(8'h10);
    chk("t1_ready", 40'(in_ready), 40'd1);
    send(4'd10, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("t1_we", 40'(mem_we), 40'd1);
    chk("t1_addr", 40'(mem_addr), 40'h10);
    chk("t1_data", 40'(mem_wdata), 40'h00500093);
    expect_wr(8'h10, 32'h00500093);
    // T2: ADD then SUB back-to-back
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    idle();
    expect_wr(8'h11, 32'h002081B3);
    expect_wr(8'h12, 32'h402081B3);
    @(negedge clk);
    chk("t2_count", 40'(count), 40'd3);
    sb_check("t12");

    // T3: BNE, SW, LUI, SRA fill the session
    do_start(8'h30);
    chk("t3_count_clr", 40'(count), 40'd0);
    send(4'd13, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
    send(4'd12, 5'd0, 5'd1, 5'd2, 32'd4);
    send(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345000);
    send(4'd7,  5'd4, 5'd5, 5'd6, 32'd0);
    idle();
    expect_wr(8'h30, 32'hFE209CE3);
    expect_wr(8'h31, 32'h0020A223);
    expect_wr(8'h32, 32'h123452B7);
    expect_wr(8'h33, 32'h4062D233);
    @(negedge clk);
    chk("t3_done", 40'(done), 40'd1);
    chk("t3_count", 40'(count), 40'd4);
    chk("t3_ready", 40'(in_ready), 40'd0);
    sb_check("t3");

    // T4: rejects set err, do not write or move the address
    do_start(8'h40);
    send(4'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(4'd14, 5'd0, 5'd1, 5'd2, 32'd3);
    send(4'd15, 5'd1, 5'd1, 5'd1, 32'd0);
    send(4'd11, 5'd1, 5'd0, 5'd0, 32'h00001001);
    idle();
    @(negedge clk);
    chk("t4_err", 40'(err), 40'd1);
    chk("t4_count", 40'(count), 40'd0);
    chk("t4_ready", 40'(in_ready), 40'd1);
    send(4'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);  // imm = -2048, boundary
    send(4'd14, 5'd0, 5'd0, 5'd0, 32'd4094);      // BEQ boundary
    idle();
    expect_wr(8'h40, 32'h80000093);
    expect_wr(8'h41, 32'h7E000FE3);
    @(negedge clk);
    chk("t4_err_sticky", 40'(err), 40'd1);
    chk("t4_count2", 40'(count), 40'd2);
    sb_check("t4");
    do_start(8'h00);
    chk("t4_err_clr", 40'(err), 40'd0);
    chk("t4_count_clr", 40'(count), 40'd0);

    // T5: wrap-around with in_valid held high, 5 requests offered
    do_start(8'hFE);
    acc = 0;
    k = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      op = 4'd10; rd = 5'(k + 1); rs1 = 5'd0; rs2 = 5'd0; imm = 32'(k + 1);
      if (in_ready === 1'b1) begin
        expect_wr(8'(8'hFE + k), t5_data[k]);
        acc++;
        k++;
      end
      @(negedge clk);
    end
    idle();
    chk("t5_accepts", 40'(acc), 40'd4);
    chk("t5_done", 40'(done), 40'd1);
    chk("t5_count", 40'(count), 40'd4);
    chk("t5_ready", 40'(in_ready), 40'd0);
    chk("t5_state", 40'(dbg_state_o), 40'd2);
    sb_check("t5");

    // T6: async reset in the cycle after an accept drops the write
    do_start(8'h20);
    op = 4'd10; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_we", 40'(mem_we), 40'd0);
    chk("t6_outputs", {mem_we, mem_addr, count, done, err}, 40'd0);
    chk("t6_wdata", 40'(mem_wdata), 40'd0);
    chk("t6_ready", 40'(in_ready), 40'd0);
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ready_idle", 40'(in_ready), 40'd0);
    idle();
    sb_check("t6");
    do_start(8'h50);
    chk("t6_ready_start", 40'(in_ready), 40'd1);
    send(4'd10, 5'd1, 5'd0, 5'd0, 32'd5);
    idle();
    expect_wr(8'h50, 32'h00500093);
    repeat (2) @(negedge clk);
    sb_check("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
